// File: rtl/bs_config_loader.sv
// Framed serial configuration loader.
// A bitstream is shifted through a chainable shadow register while a bit
// counter and a CRC-8 (poly 0x07, MSB first) track the frame. When the shift
// ends, the frame is checked. Only a frame with the right length and a zero CRC
// residue is copied into cfg_active. Readback copies cfg_active back into the
// shadow so that it can be shifted out on bs_out.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - asynchronous, active-high; clears all state
//   config_en  - high = shift one bit per cycle
//   bs_in      - serial data in (data MSB first, then CRC MSB first)
//   bs_out     - oldest shadow bit, for daisy-chaining
//   readback   - one-cycle request to load cfg_active into the shadow (IDLE only)
//   cfg_active - committed configuration; MSB is the first data bit sent
//   cfg_valid  - high once any frame has committed
//   err_len    - last checked frame had the wrong bit count
//   err_crc    - last checked frame had a CRC mismatch
//   busy       - loader is not idle
module bs_config_loader #(
    parameter int unsigned BS_LENGTH = 256,
    parameter bit          CRC_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 config_en,
    input  logic                 bs_in,
    output logic                 bs_out,
    input  logic                 readback,
    output logic [BS_LENGTH-1:0] cfg_active,
    output logic                 cfg_valid,
    output logic                 err_len,
    output logic                 err_crc,
    output logic                 busy
);

    localparam int unsigned CRC_W = CRC_EN ? 8 : 0;
    localparam int unsigned TOTAL = BS_LENGTH + CRC_W;
    localparam int unsigned CNT_W = $clog2(TOTAL + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);
    localparam logic [7:0]       POLY     = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TOTAL-1:0]     shadow_q, shadow_d;
    logic [7:0]           crc_q, crc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BS_LENGTH-1:0] cfg_active_q, cfg_active_d;
    logic                 cfg_valid_q, cfg_valid_d;
    logic                 err_len_q, err_len_d;
    logic                 err_crc_q, err_crc_d;
    logic                 busy_q, busy_d;

    logic                 len_ok;
    logic                 crc_ok;
    logic [TOTAL-1:0]     rb_image;

    // One MSB-first CRC-8 step for a single incoming bit.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    endfunction

    // Next-state, datapath and output logic.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        cfg_active_d = cfg_active_q;
        cfg_valid_d  = cfg_valid_q;
        err_len_d    = err_len_q;
        err_crc_d    = err_crc_q;

        len_ok = (cnt_q == CNT_FULL);
        crc_ok = !CRC_EN || (crc_q == 8'h00);

        // Readback image: the data field holds cfg_active and the CRC field is zero.
        rb_image = '0;
        rb_image[TOTAL-1 -: BS_LENGTH] = cfg_active_q;

        unique case (state_q)
            S_IDLE: begin
                // config_en has priority, so a readback that arrives with it is dropped.
                if (config_en) begin
                    shadow_d = {shadow_q[TOTAL-2:0], bs_in};
                    crc_d    = crc_step(8'h00, bs_in);
                    cnt_d    = CNT_W'(1);
                    state_d  = S_SHIFT;
                end else if (readback) begin
                    shadow_d = rb_image;
                end
            end
            S_SHIFT: begin
                if (config_en) begin
                    shadow_d = {shadow_q[TOTAL-2:0], bs_in};
                    crc_d    = crc_step(crc_q, bs_in);
                    // Saturate so that an overlong frame can never wrap back to a valid count.
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_len_d = !len_ok;
                err_crc_d = len_ok && !crc_ok;
                if (len_ok && crc_ok) begin
                    cfg_active_d = shadow_q[TOTAL-1 -: BS_LENGTH];
                    cfg_valid_d  = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            crc_q        <= '0;
            cnt_q        <= '0;
            cfg_active_q <= '0;
            cfg_valid_q  <= 1'b0;
            err_len_q    <= 1'b0;
            err_crc_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            cfg_active_q <= cfg_active_d;
            cfg_valid_q  <= cfg_valid_d;
            err_len_q    <= err_len_d;
            err_crc_q    <= err_crc_d;
            busy_q       <= busy_d;
        end
    end

    assign bs_out     = shadow_q[TOTAL-1];
    assign cfg_active = cfg_active_q;
    assign cfg_valid  = cfg_valid_q;
    assign err_len    = err_len_q;
    assign err_crc    = err_crc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bs_config_loader.sv
// Testbench for bs_config_loader.
// u0: BS_LENGTH=16 with CRC. u1: the same configuration, chained after u0.
// u2: BS_LENGTH=16 without CRC.
module tb_bs_config_loader;

    localparam int TOT = 24;

    logic        clk;
    logic        reset;

    logic        cfg_en0, bs_in0, rb0, bs_out0, val0, el0, ec0, busy0;
    logic [15:0] act0;
    logic        cfg_en1, rb1, bs_out1, val1, el1, ec1, busy1;
    logic [15:0] act1;
    logic        cfg_en2, bs_in2, rb2, bs_out2, val2, el2, ec2, busy2;
    logic [15:0] act2;

    bs_config_loader #(.BS_LENGTH(16), .CRC_EN(1'b1)) u0 (
        .clk(clk), .reset(reset), .config_en(cfg_en0), .bs_in(bs_in0), .bs_out(bs_out0),
        .readback(rb0), .cfg_active(act0), .cfg_valid(val0), .err_len(el0),
        .err_crc(ec0), .busy(busy0)
    );

    bs_config_loader #(.BS_LENGTH(16), .CRC_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .config_en(cfg_en1), .bs_in(bs_out0), .bs_out(bs_out1),
        .readback(rb1), .cfg_active(act1), .cfg_valid(val1), .err_len(el1),
        .err_crc(ec1), .busy(busy1)
    );

    bs_config_loader #(.BS_LENGTH(16), .CRC_EN(1'b0)) u2 (
        .clk(clk), .reset(reset), .config_en(cfg_en2), .bs_in(bs_in2), .bs_out(bs_out2),
        .readback(rb2), .cfg_active(act2), .cfg_valid(val2), .err_len(el2),
        .err_crc(ec2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state for u0.
    logic [15:0] m_active;
    logic        m_valid, m_len, m_crc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Remainder of a 24-bit polynomial modulo x^8+x^2+x+1 (0x107), by long division.
    function automatic logic [7:0] gf2_rem(input logic [23:0] v_in);
        logic [23:0] v;
        v = v_in;
        for (int i = 23; i >= 8; i--) begin
            if (v[i]) v = v ^ (24'h107 << (i - 8));
        end
        return v[7:0];
    endfunction

    function automatic logic [23:0] good_frame(input logic [15:0] d);
        return {d, gf2_rem({d, 8'h00})};
    endfunction

    // Apply one u0 frame to the reference state.
    task automatic model_frame(input logic [63:0] raw, input int n);
        if (n != TOT) begin
            m_len = 1'b1;
            m_crc = 1'b0;
        end else if (gf2_rem(raw[23:0]) != 8'h00) begin
            m_len = 1'b0;
            m_crc = 1'b1;
        end else begin
            m_len    = 1'b0;
            m_crc    = 1'b0;
            m_active = raw[23:8];
            m_valid  = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_active = '0;
        m_valid  = 1'b0;
        m_len    = 1'b0;
        m_crc    = 1'b0;
    endtask

    task automatic chk_u0(input string tag);
        chk({tag, ".cfg_active"}, 64'(act0), 64'(m_active));
        chk({tag, ".cfg_valid"},  64'(val0), 64'(m_valid));
        chk({tag, ".err_len"},    64'(el0),  64'(m_len));
        chk({tag, ".err_crc"},    64'(ec0),  64'(m_crc));
        chk({tag, ".busy"},       64'(busy0), 64'd0);
    endtask

    // Shift n bits of raw (MSB first) into u0. The error flags must hold their old values.
    task automatic send0(input logic [63:0] raw, input int n, input logic hold_rb);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("shift.busy",          64'(busy0), 64'd1);
                chk("shift.err_len_hold",  64'(el0),   64'(m_len));
                chk("shift.err_crc_hold",  64'(ec0),   64'(m_crc));
            end
            cfg_en0 = 1'b1;
            bs_in0  = raw[n-1-i];
            rb0     = hold_rb;
        end
    endtask

    // End the u0 frame: nothing may change on the edge into CHECK, and the commit happens on the next edge.
    task automatic close0();
        @(negedge clk);
        cfg_en0 = 1'b0;
        cfg_en1 = 1'b0;
        bs_in0  = 1'b0;
        @(negedge clk);
        chk("check.busy",        64'(busy0), 64'd1);
        chk("check.active_hold", 64'(act0),  64'(m_active));
        chk("check.valid_hold",  64'(val0),  64'(m_valid));
        chk("check.err_len_hold", 64'(el0),  64'(m_len));
        @(negedge clk);
        rb0 = 1'b0;
    endtask

    task automatic frame2(input logic [63:0] raw, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_en2 = 1'b1;
            bs_in2  = raw[n-1-i];
        end
        @(negedge clk);
        cfg_en2 = 1'b0;
        bs_in2  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int          kind;     // 0: data + correct CRC, 1: data + given CRC, 2: raw n bits
        int          n;
        logic [63:0] raw;
        logic [15:0] data;
        logic [7:0]  crc;
        logic [15:0] e_active;
        logic        e_valid;
        logic        e_len;
        logic        e_crc;
    } vec_t;

    typedef struct {
        logic [63:0] raw;
        int          n;
        logic [15:0] e_active;
        logic        e_valid;
        logic        e_len;
    } vec2_t;

    vec_t  vecs[5];
    vec2_t vecs2[4];

    initial begin
        logic [63:0] raw;
        logic [63:0] s;
        logic [23:0] rbexp;
        int          n;
        logic [15:0] d;

        clk = 1'b0;
        reset = 1'b1;
        cfg_en0 = 0; bs_in0 = 0; rb0 = 0;
        cfg_en1 = 0; rb1 = 0;
        cfg_en2 = 0; bs_in2 = 0; rb2 = 0;
        model_reset();

        vecs[0] = '{1, 24, 64'h0, 16'h0001, 8'h06, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{2, 23, 64'h0000_0000_0012_3456, 16'h0, 8'h0, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2, 30, 64'h0000_0000_3FFF_FFFF, 16'h0, 8'h0, 16'h0001, 1'b1, 1'b1, 1'b0};
        // 56 bits: a 5-bit counter that wrapped would see 24 and a valid tail frame.
        vecs[3] = '{2, 56, {8'h00, 32'hDEAD_BEEF, good_frame(16'h1234)}, 16'h0, 8'h0,
                    16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{0, 24, 64'h0, 16'hA5C3, 8'h00, 16'hA5C3, 1'b1, 1'b0, 1'b0};

        vecs2[0] = '{64'hFFFF,  16, 16'hFFFF, 1'b1, 1'b0};
        vecs2[1] = '{64'h7FFF,  15, 16'hFFFF, 1'b1, 1'b1};
        vecs2[2] = '{64'h1FFFF, 17, 16'hFFFF, 1'b1, 1'b1};
        vecs2[3] = '{64'h1234,  16, 16'h1234, 1'b1, 1'b0};

        // Reset values
        #3;
        chk_u0("reset");
        chk("reset.bs_out0",  64'(bs_out0), 64'd0);
        chk("reset.u1_valid", 64'(val1), 64'd0);
        chk("reset.u2_active", 64'(act2), 64'd0);
        chk("reset.u2_err_len", 64'(el2), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First good frame: latency and busy
        raw = 64'(good_frame(16'h0001));
        chk("crc_of_0001", 64'(raw[7:0]), 64'h07);
        send0(raw, TOT, 1'b0);
        close0();
        model_frame(raw, TOT);
        chk("good.active_const", 64'(act0), 64'h0001);
        chk_u0("good0001");

        // Table of single frames
        for (int v = 0; v < 5; v++) begin
            case (vecs[v].kind)
                0:       begin raw = 64'(good_frame(vecs[v].data)); n = TOT; end
                1:       begin raw = 64'({vecs[v].data, vecs[v].crc}); n = TOT; end
                default: begin raw = vecs[v].raw; n = vecs[v].n; end
            endcase
            send0(raw, n, 1'b0);
            close0();
            chk($sformatf("vec%0d.cfg_active", v), 64'(act0), 64'(vecs[v].e_active));
            chk($sformatf("vec%0d.cfg_valid", v),  64'(val0), 64'(vecs[v].e_valid));
            chk($sformatf("vec%0d.err_len", v),    64'(el0),  64'(vecs[v].e_len));
            chk($sformatf("vec%0d.err_crc", v),    64'(ec0),  64'(vecs[v].e_crc));
            m_active = vecs[v].e_active;
            m_valid  = vecs[v].e_valid;
            m_len    = vecs[v].e_len;
            m_crc    = vecs[v].e_crc;
        end

        // Readback of A5C3, then shift zeros out
        @(negedge clk);
        rb0 = 1'b1;
        @(negedge clk);
        rb0 = 1'b0;
        rbexp = 24'hA5C300;
        for (int j = 0; j < TOT; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("readback.bs_out[%0d]", j), 64'(bs_out0), 64'(rbexp[23-j]));
            cfg_en0 = 1'b1;
            bs_in0  = 1'b0;
        end
        close0();
        model_frame(64'h0, TOT);
        chk_u0("readback_zero_frame");

        // Readback held through IDLE+config_en, SHIFT and CHECK has no effect
        raw = 64'(good_frame(16'hC35A));
        send0(raw, TOT, 1'b1);
        close0();
        model_frame(raw, TOT);
        chk_u0("rb_ignored");
        chk("rb_ignored.bs_out", 64'(bs_out0), 64'(raw[23]));

        // Chain: 48 bits through u0; u1 enabled for the second half
        s = {16'h0, good_frame(16'h5A3C), good_frame(16'h0F0F)};
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k >= TOT) chk($sformatf("chain.delay[%0d]", k), 64'(bs_out0), 64'(s[47-(k-TOT)]));
            cfg_en0 = 1'b1;
            bs_in0  = s[47-k];
            cfg_en1 = (k >= TOT);
        end
        close0();
        model_frame(s, 48);
        chk_u0("chain.upstream");
        chk("chain.u1_active",  64'(act1), 64'h5A3C);
        chk("chain.u1_valid",   64'(val1), 64'd1);
        chk("chain.u1_err_len", 64'(el1),  64'd0);
        chk("chain.u1_err_crc", 64'(ec1),  64'd0);

        // Asynchronous reset at bit 10
        raw = 64'(good_frame(16'h8001));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cfg_en0 = 1'b1;
            bs_in0  = raw[23-i];
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_u0("reset_mid");
        chk("reset_mid.bs_out", 64'(bs_out0), 64'd0);
        chk("reset_mid.u1_valid", 64'(val1), 64'd0);
        chk("reset_mid.u1_active", 64'(act1), 64'd0);
        cfg_en0 = 1'b0;
        bs_in0  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        send0(raw, TOT, 1'b0);
        close0();
        model_frame(raw, TOT);
        chk_u0("after_reset");

        // No-CRC instance
        for (int v = 0; v < 4; v++) begin
            frame2(vecs2[v].raw, vecs2[v].n);
            chk($sformatf("nocrc%0d.cfg_active", v), 64'(act2), 64'(vecs2[v].e_active));
            chk($sformatf("nocrc%0d.cfg_valid", v),  64'(val2), 64'(vecs2[v].e_valid));
            chk($sformatf("nocrc%0d.err_len", v),    64'(el2),  64'(vecs2[v].e_len));
            chk($sformatf("nocrc%0d.err_crc", v),    64'(ec2),  64'd0);
        end

        // Random frames against the reference model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                rb0 = 1'b1;
                @(negedge clk);
                rb0 = 1'b0;
                chk("rand.readback_msb", 64'(bs_out0), 64'(m_active[15]));
            end
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1: begin raw = 64'(good_frame(d)); n = TOT; end
                2: begin
                    raw = {$urandom, $urandom};
                    n = ($urandom_range(0, 1) == 1) ? TOT + int'($urandom_range(1, 3))
                                                    : TOT - int'($urandom_range(1, 3));
                end
                default: begin raw = 64'({d, 8'($urandom)}); n = TOT; end
            endcase
            send0(raw, n, 1'b0);
            close0();
            model_frame(raw, n);
            chk_u0($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
